pipe_scroll: RTL and testbench

Consumer end of the pipe-column stream: accepts each new 8-row column pattern from the pipe generator at the right edge of the LED matrix. Scrolls the columns leftward across the display at a fixed tick rate, tests the bird's row against the column it occupies, and counts pipes cleared. Drives the matrix column data and the `lossDetect` signal that freezes the generator and the rest of the game.

---
 rtl/pipe_scroll.sv | 109 ++++++++++
 tb/tb_pipe_scroll.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroll.sv
// rtl/pipe_scroll.sv - scrolls pipe columns across the matrix, detects bird collision, counts pipes (optional PIPE_SCROLL_SCORE_EN)
module pipe_scroll #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int TICK     = 2560,
    parameter int BIRD_COL = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS-1:0]      newCol,
    input  logic [ROWS-1:0]      bird,
    output logic [COLS*ROWS-1:0] display,
    output logic                 shift,
    output logic                 lossDetect,
    output logic [7:0]           score
);

    localparam int CW = $clog2(TICK);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOST
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] counter;
    logic          hit;
    logic          tick_done;
    logic          step;
    logic          bird_col_lit;

    assign bird_col_lit = |display[BIRD_COL*ROWS +: ROWS];
    assign hit          = |(display[BIRD_COL*ROWS +: ROWS] & bird);
    assign tick_done    = (counter == TICK_LAST);
    // A collision on a tick edge wins: no scroll and no score on that edge.
    assign step         = (state == RUN) && !hit && tick_done;
    assign lossDetect   = (state == LOST);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (hit)   next_state = LOST;
            LOST:    if (start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            display <= '0;
            counter <= '0;
            shift   <= 1'b0;
        end else begin
            state <= next_state;
            shift <= step;
            case (state)
                IDLE: begin
                    display <= '0;
                    counter <= '0;
                end
                RUN: begin
                    if (step) begin
                        counter <= '0;
                        display <= {newCol, display[COLS*ROWS-1:ROWS]};
                    end else if (!hit) begin
                        counter <= counter + 1'b1;
                    end
                end
                LOST: begin
                    if (start) begin
                        display <= '0;
                        counter <= '0;
                    end
                end
                default: begin
                    display <= '0;
                    counter <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_SCROLL_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            score_q <= 8'd0;
        end else if (state == LOST && start) begin
            score_q <= 8'd0;
        end else if (step && bird_col_lit && score_q != 8'hFF) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    logic unused_score;
    assign unused_score = bird_col_lit;
    assign score        = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_scroll.sv
// tb/tb_pipe_scroll.sv - directed self-checking bench for pipe_scroll
module tb_pipe_scroll;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  newCol = 8'h00;
    logic [7:0]  bird = 8'h00;
    logic [63:0] display;
    logic        shift;
    logic        lossDetect;
    logic [7:0]  score;

    int compared = 0;
    int mismatched = 0;

`ifdef PIPE_SCROLL_SCORE_EN
    localparam logic [7:0] EXP_SCORE10 = 8'd3;
`else
    localparam logic [7:0] EXP_SCORE10 = 8'd0;
`endif
    localparam logic [63:0] SEVEN_PIPES = 64'hF8F8F8F8_F8F8F800;

    pipe_scroll #(
        .COLS(8), .ROWS(8), .TICK(4), .BIRD_COL(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .newCol(newCol),
        .bird(bird),
        .display(display),
        .shift(shift),
        .lossDetect(lossDetect),
        .score(score)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until the shift pulse is seen, bounded to 10 cycles.
    task automatic wait_shift(input string name);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (shift === 1'b1) seen = 1;
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s: shift pulse not seen within 10 cycles, required within 4", name);
        end
    endtask

    task automatic test_reset();
        bit bad_shift = 0;
        bit bad_disp = 0;
        do_reset();
        compared++;
        if (display !== 64'd0 || score !== 8'd0 || lossDetect !== 1'b0 || shift !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: display=%h score=%0d loss=%b shift=%b, required all 0",
                     display, score, lossDetect, shift);
        end
        newCol = 8'hF8;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (shift !== 1'b0) bad_shift = 1;
            if (display !== 64'd0 || lossDetect !== 1'b0) bad_disp = 1;
        end
        compared++;
        if (bad_shift) begin
            mismatched++;
            $display("FAIL idle_shift: shift pulsed in IDLE, required 0");
        end
        compared++;
        if (bad_disp) begin
            mismatched++;
            $display("FAIL idle_display: display/lossDetect nonzero in IDLE, required 0");
        end
    endtask

    task automatic test_scroll();
        logic [3:0] pattern;
        do_reset();
        newCol = 8'hF8;
        bird = 8'h00;
        pulse_start();
        // shift pulse is the cycle after the 4th edge following RUN entry
        for (int i = 1; i <= 4; i++) begin
            tick();
            pattern[i-1] = shift;
        end
        compared++;
        if (pattern !== 4'b1000) begin
            mismatched++;
            $display("FAIL first_shift_timing: shift pattern=%b, required 1000", pattern);
        end
        compared++;
        if (display !== 64'hF800_0000_0000_0000) begin
            mismatched++;
            $display("FAIL first_shift_display: display=%h, required f800000000000000", display);
        end
        for (int k = 2; k <= 7; k++) begin
            for (int i = 1; i <= 4; i++) begin
                tick();
                pattern[i-1] = shift;
            end
            compared++;
            if (pattern !== 4'b1000) begin
                mismatched++;
                $display("FAIL shift_period_%0d: shift pattern=%b, required 1000", k, pattern);
            end
        end
        compared++;
        if (display !== SEVEN_PIPES) begin
            mismatched++;
            $display("FAIL seven_shifts: display=%h, required %h", display, SEVEN_PIPES);
        end
        wait_shift("eighth_shift");
        compared++;
        if (display[7:0] !== 8'hF8) begin
            mismatched++;
            $display("FAIL col0_after_8: display[7:0]=%h, required f8", display[7:0]);
        end
    endtask

    task automatic test_score();
        do_reset();
        newCol = 8'hF8;
        bird = 8'b0000_0100;
        pulse_start();
        for (int k = 1; k <= 7; k++) wait_shift("score_shift");
        compared++;
        if (score !== 8'd0) begin
            mismatched++;
            $display("FAIL score_after_7: score=%0d, required 0", score);
        end
        for (int k = 8; k <= 10; k++) wait_shift("score_shift");
        compared++;
        if (score !== EXP_SCORE10 || lossDetect !== 1'b0) begin
            mismatched++;
            $display("FAIL score_after_10: score=%0d loss=%b, required %0d loss=0",
                     score, lossDetect, EXP_SCORE10);
        end
    endtask

    task automatic test_collision();
        bit bad = 0;
        do_reset();
        newCol = 8'hF8;
        bird = 8'b1000_0000;
        pulse_start();
        for (int k = 1; k <= 7; k++) wait_shift("collide_shift");
        compared++;
        if (lossDetect !== 1'b0) begin
            mismatched++;
            $display("FAIL collide_early: lossDetect=%b on shift cycle, required 0", lossDetect);
        end
        tick();
        compared++;
        if (lossDetect !== 1'b1) begin
            mismatched++;
            $display("FAIL collide_detect: lossDetect=%b, required 1", lossDetect);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (display !== SEVEN_PIPES || score !== 8'd0 || shift !== 1'b0 || lossDetect !== 1'b1)
                bad = 1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL lost_frozen: display=%h score=%0d shift=%b loss=%b, required %h 0 0 1",
                     display, score, shift, lossDetect, SEVEN_PIPES);
        end
    endtask

    task automatic test_restart();
        bit bad = 0;
        pulse_start();
        compared++;
        if (lossDetect !== 1'b0 || display !== 64'd0 || score !== 8'd0) begin
            mismatched++;
            $display("FAIL restart_idle: loss=%b display=%h score=%0d, required 0 0 0",
                     lossDetect, display, score);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (shift !== 1'b0 || display !== 64'd0) bad = 1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL restart_stays_idle: shift or display active after restart, required idle");
        end
    endtask

    task automatic test_tick_collision();
        do_reset();
        newCol = 8'hF8;
        bird = 8'h00;
        pulse_start();
        for (int k = 1; k <= 7; k++) wait_shift("tick_col_shift");
        tick();
        tick();
        tick();
        bird = 8'b1000_0000;
        tick();
        compared++;
        if (shift !== 1'b0 || lossDetect !== 1'b1 || display !== SEVEN_PIPES) begin
            mismatched++;
            $display("FAIL tick_collision: shift=%b loss=%b display=%h, required 0 1 %h",
                     shift, lossDetect, display, SEVEN_PIPES);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        newCol = 8'hF8;
        bird = 8'b0000_0100;
        pulse_start();
        for (int k = 1; k <= 8; k++) wait_shift("midrun_shift");
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        compared++;
        if (display !== 64'd0 || score !== 8'd0 || shift !== 1'b0 || lossDetect !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_midrun: display=%h score=%0d shift=%b loss=%b, required all 0",
                     display, score, shift, lossDetect);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_score();
        test_collision();
        test_restart();
        test_tick_collision();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
